// File: rtl/johnson_phase_monitor.sv
// Johnson phase monitor: samples a 4-bit Johnson counter every clock and decodes
// the eight legal codes into a registered one-hot phase and phase index. Each edge
// classifies the sample against the previous one as one of:
//   ILLEGAL, RESYNC, HOLD, ADVANCE or JUMP.
// From that class it tracks sequence lock, counts revolutions while locked and
// logs sequence errors.
// Ports:
//   clk          - clock, rising edge
//   reset_n      - synchronous active-low reset
//   count        - Johnson code from the upstream counter
//   clr_err      - clears err_count / illegal_seen (an error event on the same edge wins)
//   phase        - registered one-hot phase (8'h00 on an illegal code)
//   phase_idx    - registered phase index (holds on an illegal code)
//   step, wrap   - one-cycle pulses on a legal advance / an 8 -> 0 advance
//   rev_count    - revolutions counted while locked
//   locked       - sequence lock status
//   illegal_seen - sticky illegal-code flag
//   err_count    - saturating sequence-error count
module johnson_phase_monitor #(
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned REV_W    = 8,
  parameter int unsigned ERR_W    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       count,
  input  logic             clr_err,
  output logic [7:0]       phase,
  output logic [2:0]       phase_idx,
  output logic             step,
  output logic             wrap,
  output logic [REV_W-1:0] rev_count,
  output logic             locked,
  output logic             illegal_seen,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [7:0] LockCnt = 8'(LOCK_CNT);

  typedef enum logic [1:0] {StUnlocked, StLocking, StLocked} state_e;
  typedef enum logic [2:0] {ClsIllegal, ClsResync, ClsHold, ClsAdvance, ClsJump} cls_e;

  function automatic logic is_legal(input logic [3:0] c);
    unique case (c)
      4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8: is_legal = 1'b1;
      default:                                         is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] code_idx(input logic [3:0] c);
    unique case (c)
      4'h1:    code_idx = 3'd1;
      4'h3:    code_idx = 3'd2;
      4'h7:    code_idx = 3'd3;
      4'hF:    code_idx = 3'd4;
      4'hE:    code_idx = 3'd5;
      4'hC:    code_idx = 3'd6;
      4'h8:    code_idx = 3'd7;
      default: code_idx = 3'd0;
    endcase
  endfunction

  logic [3:0]       cnt_q;
  state_e           state_q, state_d;
  logic [7:0]       run_q, run_d;
  logic [7:0]       phase_q, phase_d;
  logic [2:0]       idx_q, idx_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic [REV_W-1:0] rev_q, rev_d;
  logic             ill_q, ill_d;
  logic [ERR_W-1:0] err_q, err_d;
  cls_e             cls;
  logic             err_event;

  // Transition classification in priority order.
  always_comb begin
    cls = ClsJump;
    if (!is_legal(count))                             cls = ClsIllegal;
    else if (!is_legal(cnt_q))                        cls = ClsResync;
    else if (count == cnt_q)                          cls = ClsHold;
    else if (code_idx(count) == code_idx(cnt_q) + 3'd1) cls = ClsAdvance;
  end

  assign err_event = (cls == ClsIllegal) || (cls == ClsJump);

  always_comb begin
    phase_d = phase_q;
    idx_d   = idx_q;
    state_d = state_q;
    run_d   = run_q;
    rev_d   = rev_q;
    ill_d   = ill_q;
    err_d   = err_q;

    if (cls == ClsIllegal) begin
      phase_d = 8'h00;
    end else begin
      idx_d   = code_idx(count);
      phase_d = 8'h01 << code_idx(count);
    end

    step_d = (cls == ClsAdvance);
    wrap_d = (cls == ClsAdvance) && (cnt_q == 4'h8) && (count == 4'h0);

    // Only revolutions completed while already locked are counted.
    if (wrap_d && state_q == StLocked) rev_d = rev_q + 1'b1;

    unique case (state_q)
      StUnlocked: begin
        if (cls == ClsAdvance) begin
          state_d = StLocking;
          run_d   = 8'd1;
        end
      end
      StLocking: begin
        if (cls == ClsAdvance) begin
          run_d = run_q + 8'd1;
          if (run_q + 8'd1 == LockCnt) state_d = StLocked;
        end else if (err_event) begin
          state_d = StUnlocked;
          run_d   = 8'd0;
        end
      end
      StLocked: begin
        if (err_event) begin
          state_d = StUnlocked;
          run_d   = 8'd0;
        end
      end
      default: begin
        state_d = StUnlocked;
        run_d   = 8'd0;
      end
    endcase

    // A same-edge error event takes precedence over clr_err.
    if (err_event) begin
      if (clr_err) begin
        err_d = ERR_W'(1);
        ill_d = (cls == ClsIllegal);
      end else begin
        if (err_q != {ERR_W{1'b1}}) err_d = err_q + 1'b1;
        if (cls == ClsIllegal)      ill_d = 1'b1;
      end
    end else if (clr_err) begin
      err_d = '0;
      ill_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q   <= 4'h0;
      state_q <= StUnlocked;
      run_q   <= 8'd0;
      phase_q <= 8'h01;
      idx_q   <= 3'd0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      rev_q   <= '0;
      ill_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      cnt_q   <= count;
      state_q <= state_d;
      run_q   <= run_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      rev_q   <= rev_d;
      ill_q   <= ill_d;
      err_q   <= err_d;
    end
  end

  assign phase        = phase_q;
  assign phase_idx    = idx_q;
  assign step         = step_q;
  assign wrap         = wrap_q;
  assign rev_count    = rev_q;
  assign locked       = (state_q == StLocked);
  assign illegal_seen = ill_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Self-checking bench for johnson_phase_monitor: a reference model predicts the
// outputs for each driven edge, pushes them to a scoreboard queue and the values
// are popped and compared just after the edge.
module tb_johnson_phase_monitor;

  localparam int unsigned LockCnt = 8;
  localparam int unsigned RevW    = 8;
  localparam int unsigned ErrW    = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [3:0]      count = 4'h0;
  logic            clr_err = 1'b0;
  logic [7:0]      phase;
  logic [2:0]      phase_idx;
  logic            step, wrap, locked, illegal_seen;
  logic [RevW-1:0] rev_count;
  logic [ErrW-1:0] err_count;

  johnson_phase_monitor #(
    .LOCK_CNT(LockCnt),
    .REV_W   (RevW),
    .ERR_W   (ErrW)
  ) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .count       (count),
    .clr_err     (clr_err),
    .phase       (phase),
    .phase_idx   (phase_idx),
    .step        (step),
    .wrap        (wrap),
    .rev_count   (rev_count),
    .locked      (locked),
    .illegal_seen(illegal_seen),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]      phase;
    logic [2:0]      idx;
    logic            step;
    logic            wrap;
    logic [RevW-1:0] rev;
    logic            locked;
    logic            ill;
    logic [ErrW-1:0] err;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model state.
  logic [3:0]      m_cnt;
  int              m_state;  // 0 unlocked, 1 locking, 2 locked
  int              m_run;
  logic [7:0]      m_phase;
  logic [2:0]      m_idx;
  logic            m_step, m_wrap, m_ill;
  logic [RevW-1:0] m_rev;
  int              m_err;

  logic [3:0] seq [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

  function automatic int find_idx(input logic [3:0] c);
    for (int i = 0; i < 8; i++) if (seq[i] == c) return i;
    return -1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [3:0] in, input logic clr, input logic rst);
    int  pi, ii;
    bit  ill, res, hold, adv, jump;
    if (!rst) begin
      m_cnt = 4'h0; m_state = 0; m_run = 0; m_phase = 8'h01; m_idx = 3'd0;
      m_step = 1'b0; m_wrap = 1'b0; m_rev = '0; m_ill = 1'b0; m_err = 0;
      return;
    end
    pi   = find_idx(m_cnt);
    ii   = find_idx(in);
    ill  = (ii < 0);
    res  = !ill && (pi < 0);
    hold = !ill && !res && (in == m_cnt);
    adv  = !ill && !res && !hold && (ii == (pi + 1) % 8);
    jump = !ill && !res && !hold && !adv;
    if (ill) m_phase = 8'h00;
    else begin
      m_phase = 8'h01 << ii;
      m_idx   = 3'(ii);
    end
    m_step = adv;
    m_wrap = adv && (m_cnt == 4'h8) && (in == 4'h0);
    if (m_wrap && m_state == 2) m_rev = m_rev + 1'b1;
    if (ill || jump) begin
      m_state = 0;
      m_run   = 0;
    end else if (adv) begin
      if (m_state == 0) begin
        m_state = 1;
        m_run   = 1;
      end else if (m_state == 1) begin
        m_run = m_run + 1;
        if (m_run == LockCnt) m_state = 2;
      end
    end
    if (ill || jump) begin
      if (clr) begin
        m_err = 1;
        m_ill = ill;
      end else begin
        m_err = (m_err < 15) ? m_err + 1 : 15;
        if (ill) m_ill = 1'b1;
      end
    end else if (clr) begin
      m_err = 0;
      m_ill = 1'b0;
    end
    m_cnt = in;
  endtask

  task automatic cycle(input logic [3:0] c, input logic clr, input logic rst);
    exp_t e;
    @(negedge clk);
    count   = c;
    clr_err = clr;
    reset_n = rst;
    model_edge(c, clr, rst);
    e.phase = m_phase; e.idx = m_idx; e.step = m_step; e.wrap = m_wrap;
    e.rev = m_rev; e.locked = (m_state == 2); e.ill = m_ill; e.err = ErrW'(m_err);
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check_eq("phase", 32'(phase), 32'(e.phase));
    check_eq("phase_idx", 32'(phase_idx), 32'(e.idx));
    check_eq("step", 32'(step), 32'(e.step));
    check_eq("wrap", 32'(wrap), 32'(e.wrap));
    check_eq("rev_count", 32'(rev_count), 32'(e.rev));
    check_eq("locked", 32'(locked), 32'(e.locked));
    check_eq("illegal_seen", 32'(illegal_seen), 32'(e.ill));
    check_eq("err_count", 32'(err_count), 32'(e.err));
  endtask

  task automatic drive(input logic [3:0] c);
    cycle(c, 1'b0, 1'b1);
  endtask

  initial begin
    logic [3:0] cur;
    // Reset.
    cycle(4'h5, 1'b1, 1'b0);
    cycle(4'h3, 1'b0, 1'b0);
    check_eq("rst_phase", 32'(phase), 32'h01);

    // Free-running sequence: three wraps, lock on the first.
    drive(4'h0);
    for (int r = 0; r < 3; r++)
      for (int i = 1; i <= 8; i++) drive(seq[i % 8]);
    check_eq("rev_after_3_wraps", 32'(rev_count), 32'd2);
    check_eq("locked_after_seq", 32'(locked), 32'd1);

    // Repeated codes while locked.
    drive(4'h1); drive(4'h3); drive(4'h7);
    drive(4'h7);
    check_eq("hold_step", 32'(step), 32'd0);
    drive(4'h7);
    check_eq("hold_phase", 32'(phase), 32'h08);
    drive(4'hF);
    check_eq("after_hold_phase", 32'(phase), 32'h10);
    check_eq("hold_locked", 32'(locked), 32'd1);

    // Illegal injection at code 3, then resync to 0.
    drive(4'hE); drive(4'hC); drive(4'h8); drive(4'h0); drive(4'h1); drive(4'h3);
    drive(4'h5);
    check_eq("ill_phase", 32'(phase), 32'h00);
    check_eq("ill_locked", 32'(locked), 32'd0);
    check_eq("ill_err", 32'(err_count), 32'd1);
    drive(4'h0);
    check_eq("resync_err", 32'(err_count), 32'd1);

    // Jumps, saturation and clr_err colliding with a jump.
    drive(4'h3);
    drive(4'hE);
    for (int i = 0; i < 20; i++) drive((i % 2 == 0) ? 4'h3 : 4'hE);
    check_eq("err_saturated", 32'(err_count), 32'd15);
    cycle(4'h3, 1'b1, 1'b1);
    check_eq("clr_jump_err", 32'(err_count), 32'd1);
    check_eq("clr_jump_ill", 32'(illegal_seen), 32'd0);
    cycle(4'h3, 1'b1, 1'b1);

    // Randomised traffic, mostly advances.
    cur = 4'h3;
    for (int i = 0; i < 300; i++) begin
      int k;
      k = find_idx(cur);
      if ($urandom_range(0, 9) < 7 && k >= 0) cur = seq[(k + 1) % 8];
      else cur = 4'($urandom_range(0, 15));
      cycle(cur, ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) != 0));
    end

    // Lock with rev_count = 5, then reset for one edge.
    cycle(4'h0, 1'b0, 1'b0);
    drive(4'h0);
    for (int r = 0; r < 6; r++)
      for (int i = 1; i <= 8; i++) drive(seq[i % 8]);
    check_eq("pre_rst_rev", 32'(rev_count), 32'd5);
    check_eq("pre_rst_locked", 32'(locked), 32'd1);
    cycle(4'h1, 1'b0, 1'b0);
    check_eq("rst_locked", 32'(locked), 32'd0);
    check_eq("rst_rev", 32'(rev_count), 32'd0);
    check_eq("rst_idx", 32'(phase_idx), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
